approx_dot_acc: RTL



---
 rtl/approx_acc_pkg.sv | 15 +
 rtl/approx_dot_acc_if.sv | 29 ++
 rtl/approx_acc_add.sv | 26 ++
 rtl/approx_dot_acc.sv | 97 +++++++++
 4 files changed

// File: rtl/approx_acc_pkg.sv
// Shared types and constants for the approximate dot-product accumulator.
// Saturating accumulation is selected with the APPROX_ACC_SAT_EN macro.
package approx_acc_pkg;

  localparam int PROD_W    = 16;
  localparam int ACC_W_DEF = 24;
  localparam int LEN_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/approx_dot_acc_if.sv
// Product-in / result-out handshake bundle for approx_dot_acc.
// The slave modport is the accumulator side; the master modport is the producer/consumer side.
interface approx_dot_acc_if #(
  parameter int ACC_W = 24,
  parameter int LEN_W = 8
);
  import approx_acc_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_prod;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic [LEN_W-1:0]  out_count;
  logic              out_ovf;

  modport master (
    output in_valid, in_prod, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_prod, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );

endinterface

// File: rtl/approx_acc_add.sv
// Combinational ACC_W-bit accumulate of one zero-extended product, with carry-out.
// With APPROX_ACC_SAT_EN defined the sum clamps to all-ones on carry; otherwise it wraps.
module approx_acc_add
  import approx_acc_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0]  acc_i,
  input  logic [PROD_W-1:0] prod_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic              carry_o
);

  logic [ACC_W:0] wide_sum;

  assign wide_sum = {1'b0, acc_i} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod_i};
  assign carry_o  = wide_sum[ACC_W];

`ifdef APPROX_ACC_SAT_EN
  // A clamped accumulator plus any product carries again, so it stays clamped.
  assign sum_o = carry_o ? {ACC_W{1'b1}} : wide_sum[ACC_W-1:0];
`else
  assign sum_o = wide_sum[ACC_W-1:0];
`endif

endmodule

// File: rtl/approx_dot_acc.sv
// Streaming frame accumulator for approximate products: IDLE/ACC/HOLD FSM, beat counter, result registers.
// Overflow behaviour (wrap vs. clamp) follows APPROX_ACC_SAT_EN via approx_acc_add.
module approx_dot_acc
  import approx_acc_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input logic              clk,
  input logic              rst_n,
  approx_dot_acc_if.slave  bus
);

  state_e           state_q;
  logic [ACC_W-1:0] acc_q;
  logic [LEN_W-1:0] cnt_q;
  logic             ovf_q;
  logic [ACC_W-1:0] out_sum_q;
  logic [LEN_W-1:0] out_cnt_q;
  logic             out_ovf_q;

  logic             accept;
  logic             in_frame;
  logic [ACC_W-1:0] acc_base;
  logic [LEN_W-1:0] cnt_base;
  logic [ACC_W-1:0] acc_d;
  logic             carry;
  logic [LEN_W-1:0] cnt_d;
  logic             ovf_d;
  logic             frame_end;

  assign bus.in_ready  = (state_q != ST_HOLD);
  assign bus.out_valid = (state_q == ST_HOLD);
  assign bus.out_sum   = out_sum_q;
  assign bus.out_count = out_cnt_q;
  assign bus.out_ovf   = out_ovf_q;

  assign accept   = bus.in_valid & bus.in_ready;
  assign in_frame = (state_q == ST_ACC);

  // The first beat of a frame adds onto zero, so IDLE and ACC share one datapath.
  assign acc_base = in_frame ? acc_q : '0;
  assign cnt_base = in_frame ? cnt_q : '0;

  approx_acc_add #(
    .ACC_W (ACC_W)
  ) u_add (
    .acc_i   (acc_base),
    .prod_i  (bus.in_prod),
    .sum_o   (acc_d),
    .carry_o (carry)
  );

  assign cnt_d     = cnt_base + LEN_W'(1);
  assign ovf_d     = (in_frame & ovf_q) | carry;
  // Reaching the all-ones count forces a flush; the counter never wraps.
  assign frame_end = bus.in_last | (&cnt_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      out_sum_q <= '0;
      out_cnt_q <= '0;
      out_ovf_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_ACC: begin
          if (accept) begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            if (frame_end) begin
              out_sum_q <= acc_d;
              out_cnt_q <= cnt_d;
              out_ovf_q <= ovf_d;
              state_q   <= ST_HOLD;
            end else begin
              state_q   <= ST_ACC;
            end
          end
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
